// File: rtl/cc_game_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cc_game_controller_pkg
//  Description : Shared game-controller definitions: state encodings, level
//                limits and the default lives / grace constants used by the
//                controller, display and tick-divider blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package cc_game_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_GRACE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    localparam int                     LEVEL_WIDTH     = 3;
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX       = 3'd7;
    localparam int                     DEF_LIVES_INIT  = 3;
    localparam int                     DEF_GRACE_TICKS = 4;
    localparam int                     GRACE_CNT_WIDTH = 4;

endpackage
`default_nettype wire

// File: rtl/cc_grace_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cc_grace_timer
//  Description : 4-bit grace tick counter with synchronous clear, advance on
//                tick and an expired flag. The count parks at GRACE_TICKS so
//                expiry stays asserted while the controller waits for the
//                collision to clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module cc_grace_timer
    import cc_game_controller_pkg::*;
#(
    parameter int GRACE_TICKS = DEF_GRACE_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    output logic expired
);

    logic [GRACE_CNT_WIDTH-1:0] r_count;

    assign expired = (r_count >= GRACE_CNT_WIDTH'(GRACE_TICKS));

    // Counter: clear has priority, then advance on tick until expiry.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (tick && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cc_game_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cc_game_controller
//  Description : Game-state sequencer behind the collision detector. Tracks
//                lives, score, level and IDLE/PLAY/GRACE/OVER, and drives the
//                shifter run-enable and display blink.
//                Optional feature macro: CC_GAME_CONTROLLER_HISCORE_EN keeps
//                a best-score register; without it HiScore reads 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module cc_game_controller
    import cc_game_controller_pkg::*;
#(
    parameter int LIVES_INIT  = DEF_LIVES_INIT,
    parameter int LIVES_WIDTH = 2,
    parameter int SCORE_WIDTH = 8,
    parameter int GRACE_TICKS = DEF_GRACE_TICKS,
    parameter int LEVEL_STEP  = 16
) (
    input  logic                   CC_GAME_CONTROLLER_CLOCK_50,
    input  logic                   CC_GAME_CONTROLLER_RESET_InHigh,
    input  logic                   CC_GAME_CONTROLLER_CollisionLow_In,
    input  logic                   CC_GAME_CONTROLLER_Tick_In,
    input  logic                   CC_GAME_CONTROLLER_Start_In,
    output logic [1:0]             CC_GAME_CONTROLLER_State_Out,
    output logic [LIVES_WIDTH-1:0] CC_GAME_CONTROLLER_Lives_Out,
    output logic [SCORE_WIDTH-1:0] CC_GAME_CONTROLLER_Score_Out,
    output logic [LEVEL_WIDTH-1:0] CC_GAME_CONTROLLER_Level_Out,
    output logic                   CC_GAME_CONTROLLER_RunEnable_Out,
    output logic                   CC_GAME_CONTROLLER_Blink_Out,
    output logic                   CC_GAME_CONTROLLER_GameOver_Out,
    output logic [SCORE_WIDTH-1:0] CC_GAME_CONTROLLER_HiScore_Out
);

    wire clk = CC_GAME_CONTROLLER_CLOCK_50;
    wire rst = CC_GAME_CONTROLLER_RESET_InHigh;

    game_state_t              r_state, w_state_nxt;
    logic [LIVES_WIDTH-1:0]   r_lives, w_lives_nxt;
    logic [SCORE_WIDTH-1:0]   r_score, w_score_nxt, w_score_inc, w_quot;
    logic [LEVEL_WIDTH-1:0]   r_level, w_level;
    logic                     r_blink, w_blink_nxt;
    logic                     r_run_en, r_game_over;
    logic                     w_hit, w_grace_clr, w_grace_tick, w_grace_expired;

    assign w_hit       = ~CC_GAME_CONTROLLER_CollisionLow_In;
    assign w_score_inc = (r_score == {SCORE_WIDTH{1'b1}}) ? r_score : r_score + 1'b1;

    // Level follows the registered score, capped at the top level.
    assign w_quot  = r_score / SCORE_WIDTH'(LEVEL_STEP);
    assign w_level = (w_quot >= SCORE_WIDTH'(LEVEL_MAX)) ? LEVEL_MAX : w_quot[LEVEL_WIDTH-1:0];

    cc_grace_timer #(
        .GRACE_TICKS (GRACE_TICKS)
    ) u_grace_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_grace_clr),
        .tick    (w_grace_tick),
        .expired (w_grace_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, lives, score, blink and grace-timer control.
    always_comb begin
        w_state_nxt  = r_state;
        w_lives_nxt  = r_lives;
        w_score_nxt  = r_score;
        w_blink_nxt  = r_blink;
        w_grace_clr  = 1'b0;
        w_grace_tick = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_lives_nxt = LIVES_WIDTH'(LIVES_INIT);
                w_score_nxt = '0;
                w_blink_nxt = 1'b0;
                w_grace_clr = 1'b1;
                if (CC_GAME_CONTROLLER_Start_In) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (w_hit) begin
                    // Hit wins over a coincident tick: score is left alone.
                    w_lives_nxt = r_lives - 1'b1;
                    w_blink_nxt = 1'b0;
                    if (r_lives <= LIVES_WIDTH'(1)) begin
                        w_lives_nxt = '0;
                        w_state_nxt = ST_OVER;
                    end else begin
                        w_state_nxt = ST_GRACE;
                        w_grace_clr = 1'b1;
                    end
                end else if (CC_GAME_CONTROLLER_Tick_In) begin
                    w_score_nxt = w_score_inc;
                end
            end
            ST_GRACE: begin
                if (CC_GAME_CONTROLLER_Tick_In) begin
                    w_score_nxt  = w_score_inc;
                    w_blink_nxt  = ~r_blink;
                    w_grace_tick = 1'b1;
                end
                if (w_grace_expired && CC_GAME_CONTROLLER_CollisionLow_In) begin
                    w_state_nxt = ST_PLAY;
                    w_blink_nxt = 1'b0;
                end
            end
            ST_OVER: begin
                if (CC_GAME_CONTROLLER_Start_In) begin
                    w_state_nxt = ST_PLAY;
                    w_lives_nxt = LIVES_WIDTH'(LIVES_INIT);
                    w_score_nxt = '0;
                    w_blink_nxt = 1'b0;
                    w_grace_clr = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath registers; run-enable and game-over track the next state so
    // the shifters stop on the same edge that enters OVER.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lives     <= LIVES_WIDTH'(LIVES_INIT);
            r_score     <= '0;
            r_level     <= '0;
            r_blink     <= 1'b0;
            r_run_en    <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_lives     <= w_lives_nxt;
            r_score     <= w_score_nxt;
            r_level     <= w_level;
            r_blink     <= w_blink_nxt;
            r_run_en    <= (w_state_nxt == ST_PLAY) || (w_state_nxt == ST_GRACE);
            r_game_over <= (w_state_nxt == ST_OVER);
        end
    end

`ifdef CC_GAME_CONTROLLER_HISCORE_EN
    logic [SCORE_WIDTH-1:0] r_hiscore;
    logic                   w_enter_over;

    assign w_enter_over = (r_state == ST_PLAY) && (w_state_nxt == ST_OVER);

    // Best score captured on entry to OVER; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hiscore <= '0;
        end else if (w_enter_over && (r_score > r_hiscore)) begin
            r_hiscore <= r_score;
        end
    end

    assign CC_GAME_CONTROLLER_HiScore_Out = r_hiscore;
`else
    assign CC_GAME_CONTROLLER_HiScore_Out = '0;
`endif

    assign CC_GAME_CONTROLLER_State_Out     = r_state;
    assign CC_GAME_CONTROLLER_Lives_Out     = r_lives;
    assign CC_GAME_CONTROLLER_Score_Out     = r_score;
    assign CC_GAME_CONTROLLER_Level_Out     = r_level;
    assign CC_GAME_CONTROLLER_RunEnable_Out = r_run_en;
    assign CC_GAME_CONTROLLER_Blink_Out     = r_blink;
    assign CC_GAME_CONTROLLER_GameOver_Out  = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_cc_game_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cc_game_controller
//  Description : Directed self-checking bench for cc_game_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cc_game_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       collision_low = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [1:0] state;
    logic [1:0] lives;
    logic [7:0] score;
    logic [2:0] level;
    logic       run_en;
    logic       blink;
    logic       game_over;
    logic [7:0] hiscore;

    int tests  = 0;
    int failed = 0;

`ifdef CC_GAME_CONTROLLER_HISCORE_EN
    localparam logic [7:0] HI_EXP = 8'd29;
`else
    localparam logic [7:0] HI_EXP = 8'd0;
`endif

    cc_game_controller dut (
        .CC_GAME_CONTROLLER_CLOCK_50        (clk),
        .CC_GAME_CONTROLLER_RESET_InHigh    (rst),
        .CC_GAME_CONTROLLER_CollisionLow_In (collision_low),
        .CC_GAME_CONTROLLER_Tick_In         (tick),
        .CC_GAME_CONTROLLER_Start_In        (start),
        .CC_GAME_CONTROLLER_State_Out       (state),
        .CC_GAME_CONTROLLER_Lives_Out       (lives),
        .CC_GAME_CONTROLLER_Score_Out       (score),
        .CC_GAME_CONTROLLER_Level_Out       (level),
        .CC_GAME_CONTROLLER_RunEnable_Out   (run_en),
        .CC_GAME_CONTROLLER_Blink_Out       (blink),
        .CC_GAME_CONTROLLER_GameOver_Out    (game_over),
        .CC_GAME_CONTROLLER_HiScore_Out     (hiscore)
    );

    always #5 clk = ~clk;

    // One clock, then settle 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_gap();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic hit_once();
        collision_low = 1'b0;
        step();
        collision_low = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        tests++; if (state !== 2'd0) begin failed++; $display("FAIL reset_state: got %0d expected 0", state); end
        tests++; if (lives !== 2'd3) begin failed++; $display("FAIL reset_lives: got %0d expected 3", lives); end
        tests++; if (score !== 8'd0) begin failed++; $display("FAIL reset_score: got %0d expected 0", score); end
        tests++; if (level !== 3'd0) begin failed++; $display("FAIL reset_level: got %0d expected 0", level); end
        tests++; if ({run_en, blink, game_over} !== 3'b000) begin failed++; $display("FAIL reset_flags: got %b expected 000", {run_en, blink, game_over}); end
        tests++; if (hiscore !== 8'd0) begin failed++; $display("FAIL reset_hiscore: got %0d expected 0", hiscore); end
        // Tick and collision are ignored in IDLE.
        collision_low = 1'b0;
        tick_gap();
        tick_gap();
        collision_low = 1'b1;
        tests++; if ({state, lives, score} !== {2'd0, 2'd3, 8'd0}) begin failed++; $display("FAIL idle_ignore: got st=%0d lv=%0d sc=%0d expected st=0 lv=3 sc=0", state, lives, score); end
    endtask

    task automatic test_play_score();
        start_pulse();
        tests++; if ({state, run_en} !== {2'd1, 1'b1}) begin failed++; $display("FAIL start_play: got st=%0d run=%0d expected st=1 run=1", state, run_en); end
        for (int i = 0; i < 20; i++) tick_gap();
        tests++; if (state !== 2'd1) begin failed++; $display("FAIL play_state: got %0d expected 1", state); end
        tests++; if (score !== 8'd20) begin failed++; $display("FAIL play_score: got %0d expected 20", score); end
        tests++; if (level !== 3'd1) begin failed++; $display("FAIL play_level: got %0d expected 1", level); end
        tests++; if (lives !== 2'd3) begin failed++; $display("FAIL play_lives: got %0d expected 3", lives); end
        // Start is ignored while playing.
        start_pulse();
        step();
        tests++; if ({state, score} !== {2'd1, 8'd20}) begin failed++; $display("FAIL start_in_play: got st=%0d sc=%0d expected st=1 sc=20", state, score); end
    endtask

    task automatic test_hit_held();
        logic exp_blink;
        exp_blink = 1'b0;
        for (int i = 0; i < 10; i++) begin
            collision_low = 1'b0;
            tick = (i % 2 == 1);
            step();
            if (tick) exp_blink = ~exp_blink;
            tests++; if (blink !== exp_blink) begin failed++; $display("FAIL held_blink_%0d: got %0d expected %0d", i, blink, exp_blink); end
        end
        tick = 1'b0;
        tests++; if ({state, lives} !== {2'd2, 2'd2}) begin failed++; $display("FAIL held_one_hit: got st=%0d lv=%0d expected st=2 lv=2", state, lives); end
        tests++; if (score !== 8'd25) begin failed++; $display("FAIL held_score: got %0d expected 25", score); end
        step();
        tests++; if (state !== 2'd2) begin failed++; $display("FAIL held_stay_grace: got %0d expected 2", state); end
        collision_low = 1'b1;
        step();
        tests++; if ({state, blink, run_en} !== {2'd1, 1'b0, 1'b1}) begin failed++; $display("FAIL held_release: got st=%0d bl=%0d run=%0d expected st=1 bl=0 run=1", state, blink, run_en); end
    endtask

    task automatic test_grace_release();
        hit_once();
        tests++; if ({state, lives} !== {2'd2, 2'd1}) begin failed++; $display("FAIL grace_enter: got st=%0d lv=%0d expected st=2 lv=1", state, lives); end
        for (int i = 0; i < 3; i++) tick_gap();
        tests++; if ({state, blink} !== {2'd2, 1'b1}) begin failed++; $display("FAIL grace_3ticks: got st=%0d bl=%0d expected st=2 bl=1", state, blink); end
        tick_gap();
        tests++; if ({state, blink, score} !== {2'd1, 1'b0, 8'd29}) begin failed++; $display("FAIL grace_expire: got st=%0d bl=%0d sc=%0d expected st=1 bl=0 sc=29", state, blink, score); end
    endtask

    task automatic test_game_over();
        hit_once();
        tests++; if ({state, lives} !== {2'd3, 2'd0}) begin failed++; $display("FAIL over_state: got st=%0d lv=%0d expected st=3 lv=0", state, lives); end
        tests++; if ({game_over, run_en} !== 2'b10) begin failed++; $display("FAIL over_flags: got go=%0d run=%0d expected go=1 run=0", game_over, run_en); end
        for (int i = 0; i < 3; i++) tick_gap();
        collision_low = 1'b0;
        step();
        collision_low = 1'b1;
        tests++; if ({state, lives, score, level} !== {2'd3, 2'd0, 8'd29, 3'd1}) begin failed++; $display("FAIL over_frozen: got st=%0d lv=%0d sc=%0d lvl=%0d expected 3/0/29/1", state, lives, score, level); end
        tests++; if (hiscore !== HI_EXP) begin failed++; $display("FAIL over_hiscore: got %0d expected %0d", hiscore, HI_EXP); end
    endtask

    task automatic test_second_game();
        start_pulse();
        step();
        tests++; if ({state, lives, score, level, game_over} !== {2'd1, 2'd3, 8'd0, 3'd0, 1'b0}) begin failed++; $display("FAIL restart: got st=%0d lv=%0d sc=%0d lvl=%0d go=%0d expected 1/3/0/0/0", state, lives, score, level, game_over); end
        for (int i = 0; i < 5; i++) tick_gap();
        tick = 1'b1;
        collision_low = 1'b0;
        step();
        tick = 1'b0;
        collision_low = 1'b1;
        tests++; if ({state, lives, score} !== {2'd2, 2'd2, 8'd5}) begin failed++; $display("FAIL tick_and_hit: got st=%0d lv=%0d sc=%0d expected st=2 lv=2 sc=5", state, lives, score); end
        for (int i = 0; i < 4; i++) tick_gap();
        hit_once();
        for (int i = 0; i < 4; i++) tick_gap();
        hit_once();
        tests++; if ({state, lives, score} !== {2'd3, 2'd0, 8'd13}) begin failed++; $display("FAIL second_over: got st=%0d lv=%0d sc=%0d expected st=3 lv=0 sc=13", state, lives, score); end
        tests++; if (hiscore !== HI_EXP) begin failed++; $display("FAIL hiscore_keep: got %0d expected %0d", hiscore, HI_EXP); end
    endtask

    task automatic test_saturate();
        start_pulse();
        for (int i = 0; i < 255; i++) tick_gap();
        tests++; if ({score, level} !== {8'd255, 3'd7}) begin failed++; $display("FAIL sat_reach: got sc=%0d lvl=%0d expected sc=255 lvl=7", score, level); end
        tick_gap();
        tests++; if ({state, score, level} !== {2'd1, 8'd255, 3'd7}) begin failed++; $display("FAIL sat_hold: got st=%0d sc=%0d lvl=%0d expected st=1 sc=255 lvl=7", state, score, level); end
    endtask

    task automatic test_reset_mid_grace();
        hit_once();
        tick_gap();
        tests++; if ({state, blink} !== {2'd2, 1'b1}) begin failed++; $display("FAIL pre_reset_grace: got st=%0d bl=%0d expected st=2 bl=1", state, blink); end
        rst = 1'b1;
        start = 1'b1;
        tick = 1'b1;
        collision_low = 1'b0;
        step();
        tests++; if ({state, lives, score, level} !== {2'd0, 2'd3, 8'd0, 3'd0}) begin failed++; $display("FAIL mid_reset_vals: got st=%0d lv=%0d sc=%0d lvl=%0d expected 0/3/0/0", state, lives, score, level); end
        tests++; if ({run_en, blink, game_over, hiscore} !== {3'b000, 8'd0}) begin failed++; $display("FAIL mid_reset_flags: got run=%0d bl=%0d go=%0d hi=%0d expected 0/0/0/0", run_en, blink, game_over, hiscore); end
        rst = 1'b0;
        start = 1'b0;
        tick = 1'b0;
        collision_low = 1'b1;
        step();
        tests++; if (state !== 2'd0) begin failed++; $display("FAIL post_reset_idle: got %0d expected 0", state); end
    endtask

    initial begin
        test_reset();
        test_play_score();
        test_hit_held();
        test_grace_release();
        test_game_over();
        test_second_game();
        test_saturate();
        test_reset_mid_grace();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
